fifo_read_ctrl: RTL and testbench

Synthesizable read-side controller for the sync FIFO.
- Issues rd_en toward the FIFO and absorbs its 1-cycle read latency in a 2-entry skid buffer.
- Presents the data as a valid/ready stream to downstream logic.
- Sits between the FIFO's read port and any consumer. It is the counterpart of the write-side stimulus driving data_in/wr_en.

---
 rtl/fifo_read_ctrl_pkg.sv | 17 +
 rtl/fifo_skid_buf.sv | 62 ++++++
 rtl/fifo_read_ctrl.sv | 79 +++++++
 tb/tb_fifo_read_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_ctrl_pkg.sv
// Shared types and constants for the FIFO read-side controller and its skid buffer.
package fifo_read_ctrl_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int SKID_DEPTH     = 2;

  typedef logic [DEF_FIFO_WIDTH-1:0]        fifo_data_t;
  typedef logic [$clog2(SKID_DEPTH+1)-1:0]  skid_cnt_t;

  // Words held plus the read in flight, minus the word leaving this cycle, must stay below the depth.
  function automatic logic hasCredit(input skid_cnt_t cnt, input logic pending, input logic pop);
    logic [2:0] inFlight;
    inFlight = 3'(cnt) + 3'(pending) - 3'(pop);
    return inFlight < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer absorbing the FIFO read latency; head entry is the output word.
module fifo_skid_buf
  import fifo_read_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head,
  output skid_cnt_t        o_count
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  skid_cnt_t        r_cnt;

  // Push into the full buffer without a pop cannot happen: the credit check in the parent prevents it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (i_push) begin
            r_head <= i_pushData;
            r_cnt  <= 2'd1;
          end
        end
        2'd1: begin
          case ({i_push, i_pop})
            2'b11: r_head <= i_pushData;
            2'b10: begin
              r_tail <= i_pushData;
              r_cnt  <= 2'd2;
            end
            2'b01: r_cnt <= 2'd0;
            default: ;
          endcase
        end
        2'd2: begin
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) r_tail <= i_pushData;
            else        r_cnt  <= 2'd1;
          end
        end
        default: r_cnt <= 2'd0;
      endcase
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_head  = r_head;
  assign o_count = r_cnt;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the sync FIFO: credit-based rd_en, skid buffer, valid/ready output.
// Optional protocol checker enabled by defining RD_CHECK_EN.
module fifo_read_ctrl
  import fifo_read_ctrl_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  empty,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  underflow,
  output logic                  rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  pop_count,
  output logic                  chk_err
);

  logic                 r_rdPending;
  logic [CNT_WIDTH-1:0] r_popCount;
  skid_cnt_t            w_bufCnt;
  logic                 w_valid;
  logic                 w_pop;
  logic                 w_rdEn;

  // rd_en depends combinationally on m_ready so a pop frees its slot in the same cycle.
  assign w_pop  = w_valid & m_ready;
  assign w_rdEn = rst_n & ~empty & hasCredit(w_bufCnt, r_rdPending, w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPending <= 1'b0;
      r_popCount  <= '0;
    end else begin
      r_rdPending <= w_rdEn;
      if (w_pop) r_popCount <= r_popCount + CNT_WIDTH'(1);
    end
  end

  fifo_skid_buf #(
    .WIDTH(FIFO_WIDTH)
  ) u_skidBuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (r_rdPending),
    .i_pushData(data_out),
    .i_pop     (w_pop),
    .o_valid   (w_valid),
    .o_head    (m_data),
    .o_count   (w_bufCnt)
  );

  assign rd_en     = w_rdEn;
  assign m_valid   = w_valid;
  assign pop_count = r_popCount;

`ifdef RD_CHECK_EN
  logic r_chkErr;

  // Sticky: an underflow right after our read, or a read issued while empty, latches until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chkErr <= 1'b0;
    end else begin
      r_chkErr <= r_chkErr | (r_rdPending & underflow) | (w_rdEn & empty);
    end
  end

  assign chk_err = r_chkErr;
`else
  logic w_unusedUnderflow;
  assign w_unusedUnderflow = underflow;
  assign chk_err           = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: behavioural FIFO model plus an in-order scoreboard.
module tb_fifo_read_ctrl;

  localparam int W  = 16;
  localparam int CW = 16;
`ifdef RD_CHECK_EN
  localparam logic CHK_EXP = 1'b1;
`else
  localparam logic CHK_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          empty = 1'b1;
  logic [W-1:0]  data_out = '0;
  logic          underflow;
  logic          rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [CW-1:0] pop_count;
  logic          chk_err;

  int errors = 0;
  int checks = 0;
  int wordsWritten = 0;
  logic [W-1:0] expQ[$];
  logic [W-1:0] wrQ[$];
  logic [W-1:0] memQ[$];

  always #5 clk = ~clk;

  fifo_read_ctrl #(
    .FIFO_WIDTH(W),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .empty    (empty),
    .data_out (data_out),
    .underflow(underflow),
    .rd_en    (rd_en),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .pop_count(pop_count),
    .chk_err  (chk_err)
  );

  // Sync FIFO model: registered empty flag, read data one cycle after rd_en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memQ.delete();
      empty    <= 1'b1;
      data_out <= '0;
    end else begin
      if (rd_en === 1'b1 && memQ.size() > 0) data_out <= memQ.pop_front();
      while (wrQ.size() > 0) memQ.push_back(wrQ.pop_front());
      empty <= (memQ.size() == 0);
    end
  end

  // Every accepted word must match the oldest word written.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      logic [W-1:0] expWord;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_extra: got m_data=%h, expected no word", m_data);
      end else begin
        expWord = expQ.pop_front();
        if (m_data !== expWord) begin
          errors++;
          $display("[TB] FAIL scoreboard_data: got m_data=%h, expected %h", m_data, expWord);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input logic [W-1:0] w);
    wrQ.push_back(w);
    expQ.push_back(w);
    wordsWritten++;
  endtask

  task automatic drainWait(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (expQ.size() == 0 && memQ.size() == 0 && m_valid === 1'b0 && rd_en === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_ready = 1'b0; underflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (m_valid !== 1'b0)   begin errors++; $display("[TB] FAIL reset_m_valid: got %b, expected 0", m_valid); end
    if (rd_en !== 1'b0)     begin errors++; $display("[TB] FAIL reset_rd_en: got %b, expected 0", rd_en); end
    if (pop_count !== '0)   begin errors++; $display("[TB] FAIL reset_pop_count: got %0d, expected 0", pop_count); end
    if (chk_err !== 1'b0)   begin errors++; $display("[TB] FAIL reset_chk_err: got %b, expected 0", chk_err); end
    if (m_data !== '0)      begin errors++; $display("[TB] FAIL reset_m_data: got %h, expected 0", m_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    bit ok;
    bit found;
    int n;
    m_ready = 1'b0;
    writeWord(16'hABCD);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (empty === 1'b0) begin ok = 1'b1; break; end
    end
    checks += 2;
    if (!ok)            begin errors++; $display("[TB] FAIL latency_empty_fall: got timeout, expected empty low"); end
    if (rd_en !== 1'b1) begin errors++; $display("[TB] FAIL latency_rd_en: got %b, expected 1", rd_en); end
    n = 0; found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (m_valid === 1'b1) begin found = 1'b1; break; end
    end
    checks += 2;
    if (!found || n != 2) begin errors++; $display("[TB] FAIL latency_cycles: got %0d (found=%0d), expected 2", n, found); end
    if (m_data !== 16'hABCD) begin errors++; $display("[TB] FAIL latency_data: got %h, expected abcd", m_data); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    drainWait(ok);
    checks += 2;
    if (!ok) begin errors++; $display("[TB] FAIL latency_drain: got timeout, expected drained"); end
    if (pop_count !== CW'(wordsWritten)) begin errors++; $display("[TB] FAIL latency_pop_count: got %0d, expected %0d", pop_count, wordsWritten); end
  endtask

  task automatic test_stream();
    bit ok;
    int rdHigh, rdRise, vHigh, vRise;
    logic prevRd, prevV;
    m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) writeWord(W'(k));
    rdHigh = 0; rdRise = 0; vHigh = 0; vRise = 0; prevRd = 1'b0; prevV = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_en === 1'b1) begin rdHigh++; if (!prevRd) rdRise++; end
      if (m_valid === 1'b1) begin vHigh++; if (!prevV) vRise++; end
      prevRd = (rd_en === 1'b1);
      prevV  = (m_valid === 1'b1);
    end
    checks += 2;
    if (rdHigh != 8 || rdRise != 1) begin errors++; $display("[TB] FAIL stream_rd_en: got %0d cycles in %0d runs, expected 8 in 1", rdHigh, rdRise); end
    if (vHigh != 8 || vRise != 1)   begin errors++; $display("[TB] FAIL stream_m_valid: got %0d cycles in %0d runs, expected 8 in 1", vHigh, vRise); end
    drainWait(ok);
    checks += 2;
    if (!ok) begin errors++; $display("[TB] FAIL stream_drain: got timeout, expected drained"); end
    if (pop_count !== CW'(wordsWritten)) begin errors++; $display("[TB] FAIL stream_pop_count: got %0d, expected %0d", pop_count, wordsWritten); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    int rdCount, stableBad;
    logic [W-1:0] first;
    m_ready = 1'b0;
    writeWord(16'h0101); writeWord(16'h0202); writeWord(16'h0303); writeWord(16'h0404);
    rdCount = 0; stableBad = 0; seen = 1'b0; first = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_en === 1'b1) rdCount++;
      if (m_valid === 1'b1) begin
        if (!seen) begin first = m_data; seen = 1'b1; end
        else if (m_data !== first) stableBad++;
      end
    end
    checks += 4;
    if (rdCount != 2)        begin errors++; $display("[TB] FAIL bp_rd_pulses: got %0d, expected 2", rdCount); end
    if (m_valid !== 1'b1)    begin errors++; $display("[TB] FAIL bp_m_valid: got %b, expected 1", m_valid); end
    if (m_data !== 16'h0101) begin errors++; $display("[TB] FAIL bp_m_data: got %h, expected 0101", m_data); end
    if (stableBad != 0)      begin errors++; $display("[TB] FAIL bp_stable: got %0d changes, expected 0", stableBad); end
    m_ready = 1'b1;
    drainWait(ok);
    checks += 2;
    if (!ok) begin errors++; $display("[TB] FAIL bp_drain: got timeout, expected drained"); end
    if (pop_count !== CW'(wordsWritten)) begin errors++; $display("[TB] FAIL bp_pop_count: got %0d, expected %0d", pop_count, wordsWritten); end
  endtask

  task automatic test_empty();
    int rdCount, vCount;
    m_ready = 1'b1;
    rdCount = 0; vCount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_en !== 1'b0) rdCount++;
      if (m_valid !== 1'b0) vCount++;
    end
    checks += 3;
    if (rdCount != 0) begin errors++; $display("[TB] FAIL empty_rd_en: got %0d cycles, expected 0", rdCount); end
    if (vCount != 0)  begin errors++; $display("[TB] FAIL empty_m_valid: got %0d cycles, expected 0", vCount); end
    if (pop_count !== CW'(wordsWritten)) begin errors++; $display("[TB] FAIL empty_pop_count: got %0d, expected %0d", pop_count, wordsWritten); end
  endtask

  task automatic test_chk();
    bit ok;
    bit seen;
    m_ready = 1'b1;
    writeWord(16'h5A5A);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_en === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL chk_rd_en: got timeout, expected rd_en"); end
    tick();
    underflow = 1'b1;
    tick();
    underflow = 1'b0;
    checks++;
    if (chk_err !== CHK_EXP) begin errors++; $display("[TB] FAIL chk_set: got %b, expected %b", chk_err, CHK_EXP); end
    repeat (5) tick();
    checks++;
    if (chk_err !== CHK_EXP) begin errors++; $display("[TB] FAIL chk_sticky: got %b, expected %b", chk_err, CHK_EXP); end
    drainWait(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL chk_drain: got timeout, expected drained"); end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    bit found;
    m_ready = 1'b0;
    writeWord(16'h1111); writeWord(16'h2222); writeWord(16'h3333); writeWord(16'h4444);
    repeat (6) tick();
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_valid: got %b, expected 1", m_valid); end
    rst_n = 1'b0;
    #1;
    expQ.delete(); wrQ.delete(); wordsWritten = 0;
    checks += 4;
    if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_m_valid: got %b, expected 0", m_valid); end
    if (pop_count !== '0) begin errors++; $display("[TB] FAIL midrst_pop_count: got %0d, expected 0", pop_count); end
    if (rd_en !== 1'b0)   begin errors++; $display("[TB] FAIL midrst_rd_en: got %b, expected 0", rd_en); end
    if (chk_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_chk_err: got %b, expected 0", chk_err); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    writeWord(16'h7777); writeWord(16'h8888);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_valid === 1'b1) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || m_data !== 16'h7777) begin errors++; $display("[TB] FAIL midrst_first: got %h (valid=%0d), expected 7777", m_data, found); end
    m_ready = 1'b1;
    drainWait(ok);
    checks += 2;
    if (!ok) begin errors++; $display("[TB] FAIL midrst_drain: got timeout, expected drained"); end
    if (pop_count !== CW'(2)) begin errors++; $display("[TB] FAIL midrst_pop_count_after: got %0d, expected 2", pop_count); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_backpressure();
    test_empty();
    test_chk();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
